// File: rtl/dds_stream_sink_pkg.sv
`timescale 1ns/1ps
// Shared widths and helpers for the DDS stream sink and its FIFO.
package dds_stream_sink_pkg;

    localparam int DDS_DATA_W  = 8;
    localparam int DDS_PHASE_W = 16;
    localparam int DDS_ENTRY_W = DDS_PHASE_W + DDS_DATA_W;
    localparam int DDS_CNT_W   = 16;

    // Statistics counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [DDS_CNT_W-1:0] sat_inc(input logic [DDS_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dds_stream_sink_if.sv
`timescale 1ns/1ps
// The two AXI-Stream channels of the DDS compiler: sine DATA and PHASE.
interface dds_stream_sink_if
    import dds_stream_sink_pkg::*;
#(
    parameter int DATA_W  = DDS_DATA_W,
    parameter int PHASE_W = DDS_PHASE_W
);

    logic [DATA_W-1:0]  s_data_tdata;
    logic               s_data_tvalid;
    logic               s_data_tready;
    logic [PHASE_W-1:0] s_phase_tdata;
    logic               s_phase_tvalid;
    logic               s_phase_tready;

    modport master (
        output s_data_tdata, s_data_tvalid, s_phase_tdata, s_phase_tvalid,
        input  s_data_tready, s_phase_tready
    );

    modport slave (
        input  s_data_tdata, s_data_tvalid, s_phase_tdata, s_phase_tvalid,
        output s_data_tready, s_phase_tready
    );

endinterface

// File: rtl/dds_stream_sink_sync_fifo.sv
`timescale 1ns/1ps
// Single-clock FIFO with registered read data, synchronous flush and a registered level.
module sync_fifo
    import dds_stream_sink_pkg::*;
#(
    parameter int WIDTH = DDS_ENTRY_W,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == LVL_FULL);
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & ~empty & ~flush;

    // NOTE: storage has no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Read data only moves on a pop, so it holds across flushes and empty slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata <= '0;
        else if (w_pop) rdata <= r_mem[r_rd_ptr];
    end

endmodule

// File: rtl/dds_stream_sink.sv
`timescale 1ns/1ps
// Joins the DDS DATA and PHASE streams, paces the samples out to a DAC and
// measures phase increment and wrap period on the acceptance side.
module dds_stream_sink
    import dds_stream_sink_pkg::*;
#(
    parameter int DATA_W     = DDS_DATA_W,
    parameter int PHASE_W    = DDS_PHASE_W,
    parameter int FIFO_DEPTH = 16,
    parameter int DAC_DIV    = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          en,
    dds_stream_sink_if.slave              s_axis,
    output logic [DATA_W-1:0]             dac_data,
    output logic                          dac_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DDS_CNT_W-1:0]          underrun_cnt,
    output logic [PHASE_W-1:0]            phase_inc,
    output logic                          inc_valid,
    output logic                          wrap_tick,
    output logic [DDS_CNT_W-1:0]          period_len
);

    localparam int ENTRY_W = PHASE_W + DATA_W;
    localparam int PACE_W  = (DAC_DIV > 1) ? $clog2(DAC_DIV) : 1;
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(DAC_DIV - 1);

    logic                 w_full;
    logic                 w_empty;
    logic                 w_xfer;
    logic                 w_tick;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_rd_entry;
    logic [PHASE_W-1:0]   w_unused_rd_phase;
    logic [PHASE_W-1:0]   w_cur_phase;
    logic [PACE_W-1:0]    r_pace;
    logic                 r_have_prev;
    logic [PHASE_W-1:0]   r_prev_phase;
    logic [DDS_CNT_W-1:0] r_samp_cnt;

    // Each ready looks only at the other channel's valid, so both handshake together or not at all.
    assign s_axis.s_data_tready  = en & ~w_full & s_axis.s_phase_tvalid;
    assign s_axis.s_phase_tready = en & ~w_full & s_axis.s_data_tvalid;
    assign w_xfer      = en & s_axis.s_data_tvalid & s_axis.s_phase_tvalid & ~w_full;
    assign w_tick      = en & (r_pace == PACE_LAST);
    assign w_pop       = w_tick & ~w_empty;
    assign w_cur_phase = s_axis.s_phase_tdata;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .flush (~en),
        .push  (w_xfer),
        .pop   (w_pop),
        .wdata ({s_axis.s_phase_tdata, s_axis.s_data_tdata}),
        .rdata (w_rd_entry),
        .full  (w_full),
        .empty (w_empty),
        .level (fifo_level)
    );

    // The FIFO read register is the DAC word; the phase half rides along unused.
    assign dac_data          = w_rd_entry[DATA_W-1:0];
    assign w_unused_rd_phase = w_rd_entry[ENTRY_W-1:DATA_W];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  r_pace <= '0;
        else if (!en)    r_pace <= '0;
        else if (w_tick) r_pace <= '0;
        else             r_pace <= r_pace + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dac_strobe   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            dac_strobe <= w_pop;
            if (w_tick && w_empty) underrun_cnt <= sat_inc(underrun_cnt);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_have_prev  <= 1'b0;
            r_prev_phase <= '0;
            r_samp_cnt   <= '0;
            phase_inc    <= '0;
            inc_valid    <= 1'b0;
            wrap_tick    <= 1'b0;
            period_len   <= '0;
        end else begin
            inc_valid <= 1'b0;
            wrap_tick <= 1'b0;
            if (!en) begin
                r_have_prev <= 1'b0;
                r_samp_cnt  <= '0;
            end else if (w_xfer) begin
                r_prev_phase <= w_cur_phase;
                if (!r_have_prev) begin
                    r_have_prev <= 1'b1;
                end else begin
                    phase_inc <= w_cur_phase - r_prev_phase;
                    inc_valid <= 1'b1;
                    // A backwards step in unsigned phase marks the accumulator wrap.
                    if (w_cur_phase < r_prev_phase) begin
                        wrap_tick  <= 1'b1;
                        period_len <= sat_inc(r_samp_cnt);
                        r_samp_cnt <= '0;
                    end else begin
                        r_samp_cnt <= sat_inc(r_samp_cnt);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_stream_sink.sv
`timescale 1ns/1ps
// Directed bench for dds_stream_sink: vector table for join/phase analysis plus
// hand-written sequences for fill, pacing, underrun, flush and async reset.
module tb_dds_stream_sink;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        en;
    logic [7:0]  dac_data;
    logic        dac_strobe;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_cnt;
    logic [15:0] phase_inc;
    logic        inc_valid;
    logic        wrap_tick;
    logic [15:0] period_len;

    int n_vec = 0;
    int n_err = 0;

    dds_stream_sink_if intf ();

    dds_stream_sink #(
        .DATA_W     (8),
        .PHASE_W    (16),
        .FIFO_DEPTH (16),
        .DAC_DIV    (4)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .en           (en),
        .s_axis       (intf.slave),
        .dac_data     (dac_data),
        .dac_strobe   (dac_strobe),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .phase_inc    (phase_inc),
        .inc_valid    (inc_valid),
        .wrap_tick    (wrap_tick),
        .period_len   (period_len)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic        en;
        logic        dv;
        logic        pv;
        logic [15:0] ph;
        logic [7:0]  dt;
        logic        exp_dr;
        logic        exp_pr;
        logic        exp_iv;
        logic        exp_wrap;
        logic [15:0] exp_inc;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_dac_data"},     32'(dac_data),     0);
        check({p, "_dac_strobe"},   32'(dac_strobe),   0);
        check({p, "_fifo_level"},   32'(fifo_level),   0);
        check({p, "_underrun_cnt"}, 32'(underrun_cnt), 0);
        check({p, "_phase_inc"},    32'(phase_inc),    0);
        check({p, "_inc_valid"},    32'(inc_valid),    0);
        check({p, "_wrap_tick"},    32'(wrap_tick),    0);
        check({p, "_period_len"},   32'(period_len),   0);
    endtask

    // Ends one clock cycle; hs reports whether the cycle just ended carried a handshake.
    task automatic step(output logic hs);
        @(negedge sys_clk);
        hs = intf.s_data_tvalid & intf.s_data_tready;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        en = 1'b0;
        intf.s_data_tvalid  = 1'b0;
        intf.s_phase_tvalid = 1'b0;
        intf.s_data_tdata   = '0;
        intf.s_phase_tdata  = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic fill_to(input logic [4:0] target);
        int   k;
        logic hs;
        k = 0;
        en = 1'b1;
        intf.s_data_tvalid  = 1'b1;
        intf.s_phase_tvalid = 1'b1;
        intf.s_phase_tdata  = 16'h0400;
        intf.s_data_tdata   = 8'h40;
        for (int i = 0; i < 100 && fifo_level != target; i++) begin
            step(hs);
            if (hs) k++;
            intf.s_phase_tdata = 16'h0400 + (16'(k) << 8);
            intf.s_data_tdata  = 8'h40 + 8'(k);
        end
    endtask

    initial begin
        logic        hs;
        int          k, win, acc, wraps, max_lvl, n_strb, idx;
        logic        exp_iv, exp_wr;
        int          strb_at  [3];
        logic [7:0]  strb_val [3];

        sys_rst_n = 1'b0;
        en = 1'b0;
        intf.s_data_tvalid  = 1'b0;
        intf.s_phase_tvalid = 1'b0;
        intf.s_data_tdata   = '0;
        intf.s_phase_tdata  = '0;
        #3;
        check_all_zero("reset");

        // Continuous stream, phase +0x100 per accepted sample.
        do_reset();
        en = 1'b1;
        intf.s_data_tvalid  = 1'b1;
        intf.s_phase_tvalid = 1'b1;
        k = 0; win = -1; acc = 0; wraps = 0; max_lvl = 0;
        for (int c = 0; c < 4000 && wraps < 2; c++) begin
            step(hs);
            exp_iv = hs && (k >= 1);
            exp_wr = hs && (k > 0) && (k % 256 == 0);
            check("t1_inc_valid", 32'(inc_valid), 32'(exp_iv));
            check("t1_wrap_tick", 32'(wrap_tick), 32'(exp_wr));
            if (exp_iv) check("t1_phase_inc", 32'(phase_inc), 32'h0100);
            if (exp_wr) begin
                check("t1_period_len", 32'(period_len), 256);
                wraps++;
            end
            if (win > 0) begin
                if (hs) acc++;
                win--;
                if (win == 0) check("t1_paced_accepts", acc, 10);
            end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (fifo_level == 5'd16) begin
                check("t1_full_tready", 32'(intf.s_data_tready), 0);
                if (win < 0) win = 40;
            end
            if (hs) k++;
            intf.s_phase_tdata = 16'(k) << 8;
            intf.s_data_tdata  = 8'(k);
        end
        check("t1_wraps", wraps, 2);
        check("t1_max_level", max_lvl, 16);

        // DATA valid without PHASE valid: nothing may be accepted.
        do_reset();
        en = 1'b1;
        intf.s_data_tvalid  = 1'b1;
        intf.s_phase_tvalid = 1'b0;
        intf.s_data_tdata   = 8'h55;
        for (int c = 0; c < 20; c++) begin
            check("t2_data_tready", 32'(intf.s_data_tready), 0);
            step(hs);
            check("t2_fifo_level", 32'(fifo_level), 0);
            check("t2_inc_valid", 32'(inc_valid), 0);
        end

        // Join and phase-analysis vectors, one row per cycle.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'hFF80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h0080, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0100};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0180, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0180, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0180, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'h0180, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h0100, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFF80};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0500, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFF80};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'h0600, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFF80};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'h0300, 8'h09, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFD00};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0400, 8'h0A, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0100};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            en = vecs[i].en;
            intf.s_data_tvalid  = vecs[i].dv;
            intf.s_phase_tvalid = vecs[i].pv;
            intf.s_phase_tdata  = vecs[i].ph;
            intf.s_data_tdata   = vecs[i].dt;
            #1;
            check($sformatf("vec%0d_data_tready", i),  32'(intf.s_data_tready),  32'(vecs[i].exp_dr));
            check($sformatf("vec%0d_phase_tready", i), 32'(intf.s_phase_tready), 32'(vecs[i].exp_pr));
            step(hs);
            check($sformatf("vec%0d_inc_valid", i), 32'(inc_valid), 32'(vecs[i].exp_iv));
            check($sformatf("vec%0d_phase_inc", i), 32'(phase_inc), 32'(vecs[i].exp_inc));
            check($sformatf("vec%0d_wrap_tick", i), 32'(wrap_tick), 32'(vecs[i].exp_wrap));
        end

        // Three samples then idle: paced strobes followed by underruns.
        do_reset();
        en = 1'b1;
        intf.s_data_tvalid  = 1'b1;
        intf.s_phase_tvalid = 1'b1;
        intf.s_data_tdata = 8'h10; intf.s_phase_tdata = 16'h1000;
        step(hs); check("t3_accept0", 32'(hs), 1);
        intf.s_data_tdata = 8'h20; intf.s_phase_tdata = 16'h1100;
        step(hs); check("t3_accept1", 32'(hs), 1);
        intf.s_data_tdata = 8'h30; intf.s_phase_tdata = 16'h1200;
        step(hs); check("t3_accept2", 32'(hs), 1);
        intf.s_data_tvalid  = 1'b0;
        intf.s_phase_tvalid = 1'b0;
        n_strb = 0; idx = 3;
        strb_at = '{0, 0, 0};
        strb_val = '{8'h00, 8'h00, 8'h00};
        for (int c = 0; c < 40 && n_strb < 3; c++) begin
            step(hs);
            idx++;
            if (dac_strobe) begin
                strb_at[n_strb]  = idx;
                strb_val[n_strb] = dac_data;
                n_strb++;
            end
        end
        check("t3_strobe_count", n_strb, 3);
        check("t3_first_latency", strb_at[0], 4);
        check("t3_gap01", strb_at[1] - strb_at[0], 4);
        check("t3_gap12", strb_at[2] - strb_at[1], 4);
        check("t3_val0", 32'(strb_val[0]), 32'h10);
        check("t3_val1", 32'(strb_val[1]), 32'h20);
        check("t3_val2", 32'(strb_val[2]), 32'h30);
        check("t3_underrun_before", 32'(underrun_cnt), 0);
        for (int c = 0; c < 16; c++) begin
            step(hs);
            check("t3_no_strobe", 32'(dac_strobe), 0);
        end
        check("t3_underrun_after", 32'(underrun_cnt), 4);
        check("t3_dac_hold", 32'(dac_data), 32'h30);

        // Drop en with five entries buffered.
        do_reset();
        fill_to(5'd5);
        check("t6_level_reached", 32'(fifo_level), 5);
        en = 1'b0;
        #1;
        check("t6_data_tready_off", 32'(intf.s_data_tready), 0);
        check("t6_phase_tready_off", 32'(intf.s_phase_tready), 0);
        step(hs);
        check("t6_flushed_level", 32'(fifo_level), 0);
        check("t6_dac_hold", 32'(dac_data), 32'h40);
        step(hs);
        intf.s_phase_tdata = 16'h0000;
        en = 1'b1;
        step(hs);
        check("t6_reenable_accept", 32'(hs), 1);
        check("t6_first_inc_valid", 32'(inc_valid), 0);
        check("t6_first_wrap_tick", 32'(wrap_tick), 0);
        intf.s_phase_tdata = 16'h0100;
        step(hs);
        check("t6_second_inc_valid", 32'(inc_valid), 1);
        check("t6_second_phase_inc", 32'(phase_inc), 32'h0100);
        check("t6_second_wrap_tick", 32'(wrap_tick), 0);

        // Asynchronous reset mid-stream with ten entries buffered.
        do_reset();
        fill_to(5'd10);
        check("t5_level_reached", 32'(fifo_level), 10);
        #1 sys_rst_n = 1'b0;
        #1 check_all_zero("t5_async");
        #1 sys_rst_n = 1'b1;
        intf.s_phase_tdata = 16'h3000;
        step(hs);
        check("t5_first_accept", 32'(hs), 1);
        check("t5_first_inc_valid", 32'(inc_valid), 0);
        intf.s_phase_tdata = 16'h3100;
        step(hs);
        check("t5_second_inc_valid", 32'(inc_valid), 1);
        check("t5_second_phase_inc", 32'(phase_inc), 32'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
